clkdiv_freq_monitor: RTL

- Receive-side checker for the fractional divided clock (nominal 100 MHz / 3.5 = 28.57 MHz).
- Samples the divided clock asynchronously in the 100 MHz source-clock domain and counts its rising edges over a fixed gate window.
- Compares each window count against a programmed range and reports `locked` plus a sticky `fault`, so firmware and the bus logic know the 28 MHz domain is running and correct.

---
 rtl/clkdiv_freq_monitor.sv | 121 ++++++++++++
 1 files changed

// File: rtl/clkdiv_freq_monitor.sv
// Frequency monitor for the fractional divided clock: counts synchronized clk_mon
// rising edges over a fixed hclkin gate window and reports lock / sticky fault.
//
// state | meaning
// IDLE  | counters and lock history cleared, waiting for enable
// MEAS  | gate window running, counting clk_mon rising edges
module clkdiv_freq_monitor #(
  parameter int GATE_CYCLES = 1000,
  parameter int EXP_MIN     = 280,
  parameter int EXP_MAX     = 290,
  parameter int LOCK_COUNT  = 4,
  parameter int CNT_W       = 16
) (
  input  logic             hclkin,
  input  logic             resetn,
  input  logic             clk_mon,
  input  logic             enable,
  input  logic             fault_clr,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             locked,
  output logic             fault
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(EXP_MAX);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(LOCK_COUNT);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t           state, state_next;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] gate_cnt;
  logic [CNT_W-1:0] edge_acc;
  logic [CNT_W-1:0] acc_next;
  logic [RUN_W-1:0] good_run;
  logic [RUN_W-1:0] run_inc;
  logic             measuring;
  logic             win_end;
  logic             in_range;
  logic             fault_set;

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_mon;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = MEAS;
      MEAS:    if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Terminal count includes the rise of the terminal cycle so no edge is lost
  // across the window boundary.
  assign acc_next  = (&edge_acc) ? edge_acc : edge_acc + CNT_W'(rise);
  assign measuring = (state == MEAS) && enable;
  assign win_end   = measuring && (gate_cnt == GATE_LAST);
  assign in_range  = (acc_next >= MIN_CNT) && (acc_next <= MAX_CNT);
  assign run_inc   = (good_run == RUN_MAX) ? good_run : good_run + 1'b1;
  assign fault_set = win_end && !in_range && locked;

  always_ff @(posedge hclkin or negedge resetn) begin
    if (!resetn) begin
      gate_cnt    <= '0;
      edge_acc    <= '0;
      good_run    <= '0;
      edge_count  <= '0;
      count_valid <= 1'b0;
      locked      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (win_end) begin
        gate_cnt    <= '0;
        edge_acc    <= '0;
        edge_count  <= acc_next;
        count_valid <= 1'b1;
        if (in_range) begin
          good_run <= run_inc;
          locked   <= (run_inc == RUN_MAX);
        end else begin
          good_run <= '0;
          locked   <= 1'b0;
        end
      end else if (measuring) begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_acc <= acc_next;
      end else begin
        // Idle or aborting a window: partial count discarded, lock history lost.
        gate_cnt <= '0;
        edge_acc <= '0;
        good_run <= '0;
        locked   <= 1'b0;
      end
      if (fault_set)      fault <= 1'b1;
      else if (fault_clr) fault <= 1'b0;
    end
  end

endmodule
